// File: rtl/nn_layer_sequencer_pkg.sv
// Shared constants and FSM state type for the 4-6-2 inference sequencer.
package nn_pkg;
  localparam int WWIDTH  = 8;
  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 4;
  localparam int N_IN    = 4;
  localparam int N_HID   = 6;
  localparam int N_OUT   = 2;
  localparam int L1_BASE = 0;
  localparam int L2_BASE = 8;
  localparam int SHIFT   = 7;
  localparam int X_W     = 9;
  localparam int H_W     = 8;
  localparam int ACC_W   = 20;

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, DONE} state_t;
endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Host handshake plus weight-RAM read port of the sequencer.
interface nn_layer_sequencer_if;
  import nn_pkg::*;
  logic                     start;
  logic signed [X_W-1:0]    x0, x1, x2, x3;
  logic                     busy;
  logic                     done;
  logic                     y0, y1;
  logic [N_HID*H_W-1:0]     hidden;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_rdata;

  modport slave  (input  start, x0, x1, x2, x3, mem_rdata,
                  output busy, done, y0, y1, hidden, mem_addr);
  modport master (output start, x0, x1, x2, x3, mem_rdata,
                  input  busy, done, y0, y1, hidden, mem_addr);
endinterface

// File: rtl/nn_layer_sequencer_dot6.sv
// Combinational signed dot product: NUM_LANES signed operands times signed weights.
module nn_dot6_lane #(
  parameter int A_W   = 9,
  parameter int VEC_W = 8
) (
  input  logic signed [A_W-1:0]       a,
  input  logic signed [VEC_W-1:0]     w,
  output logic signed [A_W+VEC_W-1:0] p
);
  localparam int P_W = A_W + VEC_W;
  assign p = P_W'(a) * P_W'(w);
endmodule

module nn_dot6 #(
  parameter int NUM_LANES = 6,
  parameter int A_W       = 9,
  parameter int VEC_W     = 8,
  parameter int ACC_W     = 20
) (
  input  logic [NUM_LANES-1:0][A_W-1:0]   a,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] w,
  output logic signed [ACC_W-1:0]         dot
);
  localparam int P_W = A_W + VEC_W;
  logic [NUM_LANES-1:0][P_W-1:0] prod;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    nn_dot6_lane #(.A_W(A_W), .VEC_W(VEC_W)) u_lane (
      .a (a[i]),
      .w (w[i]),
      .p (prod[i])
    );
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < NUM_LANES; i++) dot = dot + ACC_W'(signed'(prod[i]));
  end
endmodule

// File: rtl/nn_layer_sequencer.sv
// Runs one 4-6-2 inference: one RAM word per neuron, FETCH then CAPTURE,
// results published together when the last output neuron lands.
module nn_layer_sequencer #(
  parameter int WWIDTH  = nn_pkg::WWIDTH,
  parameter int SHIFT   = nn_pkg::SHIFT,
  parameter int L1_BASE = nn_pkg::L1_BASE,
  parameter int L2_BASE = nn_pkg::L2_BASE
) (
  input  logic                  CLK,
  input  logic                  RST,
  nn_layer_sequencer_if.slave   bus
);
  import nn_pkg::*;

  localparam logic [2:0] K_HID_LAST = 3'(N_HID - 1);
  localparam logic [2:0] K_OUT_LAST = 3'(N_OUT - 1);

  state_t                           state, state_d;
  logic [1:0]                       layer, layer_d;
  logic [2:0]                       k, k_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic                             accept, cap_en;

  logic [N_IN-1:0][X_W-1:0]         x_q;
  logic [N_HID-1:0][H_W-1:0]        h_work, hidden_q;
  logic                             y0_work, y0_q, y1_q;

  logic [N_HID-1:0][X_W-1:0]        opnd;
  logic [N_HID-1:0][WWIDTH-1:0]     wts;
  logic signed [ACC_W-1:0]          dot, sh;
  logic [H_W-1:0]                   h_new;
  logic                             y_new;
  logic [ADDR_W-1:0]                base;
  logic                             unused_rdata;

  assign base = (layer == 2'd2) ? ADDR_W'(L2_BASE) : ADDR_W'(L1_BASE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      layer  <= 2'd1;
      k      <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_d;
      layer  <= layer_d;
      k      <= k_d;
      addr_q <= addr_d;
    end
  end

  // The address register leads the FSM: it is loaded on the edge that enters
  // FETCH so the RAM sees it for the whole FETCH cycle.
  always_comb begin
    state_d = state;
    layer_d = layer;
    k_d     = k;
    addr_d  = addr_q;
    accept  = 1'b0;
    cap_en  = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        state_d = FETCH;
        layer_d = 2'd1;
        k_d     = '0;
        addr_d  = ADDR_W'(L1_BASE);
        accept  = 1'b1;
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        cap_en = 1'b1;
        if (layer == 2'd1 && k == K_HID_LAST) begin
          state_d = FETCH;
          layer_d = 2'd2;
          k_d     = '0;
          addr_d  = ADDR_W'(L2_BASE);
        end else if (layer == 2'd2 && k == K_OUT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          k_d     = k + 3'd1;
          addr_d  = base + ADDR_W'(k + 3'd1);
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // Layer 1 leaves lanes 4,5 at zero so their weight bytes drop out.
  always_comb begin
    opnd = '0;
    if (layer == 2'd1) for (int i = 0; i < N_IN; i++) opnd[i] = x_q[i];
    else for (int j = 0; j < N_HID; j++) opnd[j] = {1'b0, h_work[j]};
  end

  assign wts          = bus.mem_rdata[N_HID*WWIDTH-1:0];
  assign unused_rdata = ^bus.mem_rdata[DATA_W-1:N_HID*WWIDTH];

  nn_dot6 #(.NUM_LANES(N_HID), .A_W(X_W), .VEC_W(WWIDTH), .ACC_W(ACC_W)) u_dot (
    .a   (opnd),
    .w   (wts),
    .dot (dot)
  );

  assign sh    = dot >>> SHIFT;
  assign h_new = (dot[ACC_W-1] || dot == '0) ? '0 :
                 (|sh[ACC_W-1:H_W])          ? '1 : sh[H_W-1:0];
  assign y_new = !dot[ACC_W-1] && (dot != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q      <= '0;
      h_work   <= '0;
      y0_work  <= 1'b0;
      hidden_q <= '0;
      y0_q     <= 1'b0;
      y1_q     <= 1'b0;
    end else begin
      if (accept) x_q <= {bus.x3, bus.x2, bus.x1, bus.x0};
      if (cap_en && layer == 2'd1)
        for (int j = 0; j < N_HID; j++) if (k == 3'(j)) h_work[j] <= h_new;
      if (cap_en && layer == 2'd2 && k == '0) y0_work <= y_new;
      // Publish all results at once so the host never sees a half-updated set.
      if (cap_en && layer == 2'd2 && k == K_OUT_LAST) begin
        hidden_q <= h_work;
        y0_q     <= y0_work;
        y1_q     <= y_new;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.mem_addr = addr_q;
  assign bus.hidden   = hidden_q;
  assign bus.y0       = y0_q;
  assign bus.y1       = y1_q;
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed and randomized bench for nn_layer_sequencer with an arithmetic reference model.
module tb_nn_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  logic [255:0] ram [16];
  int           xs [4];
  logic [47:0]  eh, prev_h;
  logic         ey0, ey1, prev_y0, prev_y1;

  nn_layer_sequencer_if bus();

  nn_layer_sequencer dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External weight RAM: registered read.
  always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic over the neuron words.
  task automatic model();
    int  z, s, h[6];
    byte w;
    for (int n = 0; n < 6; n++) begin
      z = 0;
      for (int i = 0; i < 4; i++) begin
        w = ram[n][i*8 +: 8];
        z += xs[i] * int'(w);
      end
      h[n] = (z <= 0) ? 0 : ((z / 128 > 255) ? 255 : z / 128);
      eh[n*8 +: 8] = 8'(h[n]);
    end
    for (int m = 0; m < 2; m++) begin
      s = 0;
      for (int j = 0; j < 6; j++) begin
        w = ram[8+m][j*8 +: 8];
        s += h[j] * int'(w);
      end
      if (m == 0) ey0 = (s > 0); else ey1 = (s > 0);
    end
  endtask

  task automatic drive_x();
    bus.x0 = 9'(xs[0]); bus.x1 = 9'(xs[1]); bus.x2 = 9'(xs[2]); bus.x3 = 9'(xs[3]);
  endtask

  task automatic randomize_all();
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 8; b++) ram[a][b*32 +: 32] = $urandom();
    for (int i = 0; i < 4; i++) xs[i] = $urandom_range(0, 255);
  endtask

  // One run from an idle DUT; caller must be at a negedge.
  task automatic run(input string tag, input bit chg_x, input bit mid_start);
    int ea;
    model();
    drive_x();
    bus.start = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c == 0) bus.start = 1'b0;
      if (mid_start) bus.start = (c == 5);
      if (chg_x && c == 3) begin
        bus.x0 = 9'($urandom_range(0, 255)); bus.x1 = 9'($urandom_range(0, 255));
        bus.x2 = 9'($urandom_range(0, 255)); bus.x3 = 9'($urandom_range(0, 255));
      end
      ea = (c >= 16) ? 9 : ((c / 2 < 6) ? c / 2 : c / 2 + 2);
      check({tag, "_addr"}, 64'(bus.mem_addr), 64'(ea));
      check({tag, "_busy"}, 64'(bus.busy), 64'(1));
      check({tag, "_done"}, 64'(bus.done), 64'(c == 16));
      if (c < 16) begin
        check({tag, "_hold_h"}, 64'(bus.hidden), 64'(prev_h));
        check({tag, "_hold_y0"}, 64'(bus.y0), 64'(prev_y0));
        check({tag, "_hold_y1"}, 64'(bus.y1), 64'(prev_y1));
      end else begin
        check({tag, "_hidden"}, 64'(bus.hidden), 64'(eh));
        check({tag, "_y0"}, 64'(bus.y0), 64'(ey0));
        check({tag, "_y1"}, 64'(bus.y1), 64'(ey1));
      end
    end
    prev_h = eh; prev_y0 = ey0; prev_y1 = ey1;
    repeat (mid_start ? 3 : 1) begin
      @(negedge clk);
      check({tag, "_idle_busy"}, 64'(bus.busy), 64'(0));
      check({tag, "_idle_done"}, 64'(bus.done), 64'(0));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    xs = '{0, 0, 0, 0};
    drive_x();
    for (int a = 0; a < 16; a++) ram[a] = '0;
    prev_h = '0; prev_y0 = 1'b0; prev_y1 = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_y0", 64'(bus.y0), 64'(0));
    check("rst_y1", 64'(bus.y1), 64'(0));
    check("rst_hidden", 64'(bus.hidden), 64'(0));
    check("rst_addr", 64'(bus.mem_addr), 64'(0));
    rst = 1'b0;

    xs = '{10, 20, 30, 40};
    run("zero_ram", 1'b0, 1'b0);

    ram[0][7:0] = 8'd1; ram[8][7:0] = 8'd1; ram[9][7:0] = 8'hFF;
    xs = '{128, 0, 0, 0};
    run("unit", 1'b0, 1'b0);
    check("unit_h", 64'(bus.hidden), 64'(1));
    check("unit_y0", 64'(bus.y0), 64'(1));
    check("unit_y1", 64'(bus.y1), 64'(0));

    // Upper bytes carry junk that must be ignored.
    ram[0] = {{7{$urandom()}}, 32'h7F7F_7F7F};
    ram[1] = {{7{$urandom()}}, 32'h8080_8080};
    xs = '{255, 255, 255, 255};
    run("sat", 1'b0, 1'b0);
    check("sat_h0", 64'(bus.hidden[7:0]), 64'(255));
    check("sat_h1", 64'(bus.hidden[15:8]), 64'(0));

    for (int r = 0; r < 6; r++) begin
      randomize_all();
      run("rand", (r == 2), (r == 4));
    end

    // Reset lands at E7 of a run.
    randomize_all();
    drive_x();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_addr", 64'(bus.mem_addr), 64'(0));
    check("abort_hidden", 64'(bus.hidden), 64'(0));
    rst = 1'b0;
    prev_h = '0; prev_y0 = 1'b0; prev_y1 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'(0));
    end
    run("after_rst", 1'b0, 1'b0);

    // start held high: runs restart every 18 cycles.
    randomize_all();
    model();
    drive_x();
    bus.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("held_done", 64'(bus.done), 64'(c == 16 || c == 34));
      check("held_busy", 64'(bus.busy), 64'(c != 17 && c != 35));
      if (c == 16 || c == 34) begin
        check("held_hidden", 64'(bus.hidden), 64'(eh));
        check("held_y0", 64'(bus.y0), 64'(ey0));
        check("held_y1", 64'(bus.y1), 64'(ey1));
      end
    end
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("final_idle", 64'(bus.busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Controller that runs one complete inference of the 4-6-2 feed-forward network: it sequences the 256-bit weight RAM one neuron word at a time and computes hidden activations, then the two binary outputs. It takes a start/busy/done handshake from the host FSM, latches the inputs, and owns the RAM read address. The weight RAM itself sits outside the block: 16 x 256, write disabled, registered read.

## Interface
- WWIDTH, 8: width of one signed weight; weight i of a word is bits [(i+1)*WWIDTH-1 : i*WWIDTH].
- SHIFT, 7: arithmetic right shift applied to layer-1 sums before saturation.
- L1_BASE, 0: RAM address of hidden neuron 0; hidden neuron n is at L1_BASE+n, n=0..5.
- L2_BASE, 8: RAM address of output neuron 0; output neuron m is at L2_BASE+m, m=0..1.

Ports:
- CLK  in  1  single clock; all logic is posedge.
- RST  in  1  reset, synchronous and active-high.
- start  in  1  request one inference; sampled only in IDLE.
- x0, x1, x2, x3  in  9 each  signed inputs, range 0..255; latched when start is accepted.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse; y0/y1/hidden are valid from this cycle on.
- y0, y1  out  1 each  output neuron m is 1 iff its sum > 0; held until the next done.
- hidden  out  48  h5..h0, 8 bits unsigned each, h0 in [7:0]; held until the next done.
- mem_addr  out  4  RAM read address.
- mem_rdata  in  256  RAM read data; valid one cycle after mem_addr is presented.

## Operation
- States: IDLE, FETCH, CAPTURE, DONE. Layer select l (1/2) and neuron index k (0..5 or 0..1) are registers.
- IDLE: if start, latch x0..x3, set l=1 and k=0, go to FETCH. Otherwise stay in IDLE.
- FETCH: drive mem_addr = base(l)+k, then go to CAPTURE.
- CAPTURE: mem_rdata holds the neuron word. Compute the neuron and register its result, then move on:
  - to FETCH with k+1;
  - at the end of layer 1, to FETCH with l=2, k=0;
  - after output neuron 1, to DONE.
- Layer 1 arithmetic: z = sum over i=0..3 of x_i * w_i.
  - 9b x 8b gives a 17b signed product; the sum is 19b signed.
  - h_k = min(255, max(0, z) >>> SHIFT).
- Layer 2 arithmetic: s = sum over j=0..5 of {1'b0,h_j} * w_j, 20b signed. y_m = (s > 0); s = 0 gives 0.
- Weight bytes beyond the ones used are ignored: bytes 4..31 in layer-1 words, bytes 6..31 in layer-2 words.
- DONE: pulse done, deassert busy, return to IDLE. A start held high therefore begins a new run on the cycle after done.
- start while busy is ignored and not queued. Changes to x_i after acceptance have no effect on the current run.
- RST at any time, including mid-run: next state IDLE; no done is issued for the aborted run.
- Reset values: busy=0, done=0, y0=y1=0, hidden=0, mem_addr=0, k=0, l=1.

## Timing
- Let edge E0 be the edge that accepts start.
- Neuron n's address is driven after edge E(2n); its result registers at edge E(2n+2).
  - Hidden neurons are n=0..5; output neurons are n=6,7.
  - mem_addr sequence for defaults: 0,0,1,1,2,2,3,3,4,4,5,5,8,8,9,9; it holds its last value in IDLE.
- y1 and the DONE transition occur at E16; done is high during the cycle after E16. Latency is 16 cycles, start-accept to done.
- busy is high from after E0 through the done cycle, inclusive.
- Back-to-back runs: minimum period 18 cycles.

## Structure
- Shared package nn_pkg holds:
  - WWIDTH, DATA_W=256, ADDR_W=4;
  - N_IN=4, N_HID=6, N_OUT=2;
  - L1_BASE, L2_BASE;
  - the state enum.
- One sub-module, nn_dot6: combinational signed dot product of six 9-bit signed operands with six WWIDTH weights, producing a 20b result.
  - Layer 1 zero-fills lanes 4,5; its 19b result is the low bits.
  - Layer 2 feeds {1'b0,h_j}.

## Test plan
- All-zero RAM, x={10,20,30,40}, start pulse -> mem_addr sequence as in Timing; done at cycle 16; y0=y1=0, hidden=0.
- Neuron 0 word w0=1, x0=128, others 0; L2 word 8 w0=1, word 9 w0=-1 -> h0=1, y0=1, y1=0.
- x all 255, neuron 0 weights all 127 (z=129540) -> h0=255 (saturated); neuron 1 weights all -128 -> h1=0 (ReLU).
- start held high for 40 cycles -> done pulses at cycles 16 and 34; a start asserted during busy is not queued.
- RST asserted at cycle 7 of a run -> IDLE next cycle, busy=0, no done; a fresh start then completes normally in 16 cycles.
- x changed at cycle 3 of a run -> results match the latched x; hidden and y hold their old values until the next done.
